// File: rtl/frame_packer.sv
// Packs a byte stream MSB-first into FRAME_W-bit frames and launches each one with a start pulse.
// Optional FRAME_PACKER_ZERO_PAD_EN: s_last ends a frame early and zero-fills the low bytes.
module frame_packer #(
  parameter int unsigned BYTE_W  = 8,
  parameter int unsigned FRAME_W = 192,
  parameter int unsigned CNT_W   = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [BYTE_W-1:0]  s_data,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic               s_last,
  output logic [FRAME_W-1:0] frame_data,
  output logic               frame_start,
  input  logic               ds_busy,
  input  logic               ds_done,
  output logic [CNT_W-1:0]   frame_count,
  output logic               in_flight
);

  localparam int unsigned NBEATS = FRAME_W / BYTE_W;
  localparam int unsigned BEAT_W = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NBEATS - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

  state_t              state_q, state_d;
  logic [FRAME_W-1:0]  asm_q, asm_shift, asm_next;
  logic [BEAT_W-1:0]   beat_q;
  logic                asm_full_q, asm_full_d;
  logic                ready_q, start_q;
  logic [FRAME_W-1:0]  frame_q;
  logic [CNT_W-1:0]    count_q;
  logic                accept, frame_end, load, launch;

  assign accept = s_valid && ready_q;

  // Shifting in at the bottom leaves byte 0 in the top slot once all NBEATS bytes are in.
  assign asm_shift = {asm_q[FRAME_W-BYTE_W-1:0], s_data};

`ifdef FRAME_PACKER_ZERO_PAD_EN
  int unsigned pad_sh;
  assign frame_end = accept && ((beat_q == LAST_BEAT) || s_last);
  // A short frame is left-justified so unfilled low-order bytes read as zero.
  always_comb begin
    pad_sh   = BYTE_W * 32'(LAST_BEAT - beat_q);
    asm_next = s_last ? (asm_shift << pad_sh) : asm_shift;
  end
`else
  logic unused_s_last;
  assign unused_s_last = s_last;
  assign frame_end     = accept && (beat_q == LAST_BEAT);
  assign asm_next      = asm_shift;
`endif

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    launch  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (asm_full_q) begin
          load    = 1'b1;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (!ds_busy) begin
          launch  = 1'b1;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (ds_done) begin
          if (asm_full_q) begin
            load    = 1'b1;
            state_d = S_ISSUE;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_flight = (state_q != S_IDLE);
  end

  // Load (asm_full set) and accept (asm_full clear) can never coincide on one edge.
  always_comb begin
    asm_full_d = asm_full_q;
    if (load)      asm_full_d = 1'b0;
    if (frame_end) asm_full_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      asm_q      <= '0;
      beat_q     <= '0;
      asm_full_q <= 1'b0;
      ready_q    <= 1'b0;
      frame_q    <= '0;
      start_q    <= 1'b0;
      count_q    <= '0;
    end else begin
      asm_full_q <= asm_full_d;
      ready_q    <= !asm_full_d;
      start_q    <= launch;
      if (accept) begin
        asm_q  <= asm_next;
        beat_q <= frame_end ? '0 : beat_q + BEAT_W'(1);
      end
      if (load)   frame_q <= asm_q;
      if (launch) count_q <= count_q + CNT_W'(1);
    end
  end

  assign s_ready     = ready_q;
  assign frame_data  = frame_q;
  assign frame_start = start_q;
  assign frame_count = count_q;

endmodule

// File: tb/tb_frame_packer.sv
// Directed self-checking bench for frame_packer: table of single-frame cases plus corner sequences.
`timescale 1ns/1ps
module tb_frame_packer;

  logic         clk = 1'b0;
  logic         reset;
  logic [7:0]   s_data;
  logic         s_valid, s_last, ds_busy, ds_done;
  logic         s_ready, frame_start, in_flight;
  logic [191:0] frame_data;
  logic [15:0]  frame_count;

  logic         s_ready_s, frame_start_s, in_flight_s;
  logic [191:0] frame_data_s;
  logic [2:0]   count_s;

  always #5 clk = ~clk;

  frame_packer dut (
    .clk(clk), .reset(reset), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .s_last(s_last), .frame_data(frame_data), .frame_start(frame_start),
    .ds_busy(ds_busy), .ds_done(ds_done), .frame_count(frame_count), .in_flight(in_flight)
  );

  // Narrow counter copy on the same stimulus so the wrap is reached in a few frames.
  frame_packer #(.CNT_W(3)) dut_small (
    .clk(clk), .reset(reset), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready_s),
    .s_last(s_last), .frame_data(frame_data_s), .frame_start(frame_start_s),
    .ds_busy(ds_busy), .ds_done(ds_done), .frame_count(count_s), .in_flight(in_flight_s)
  );

  int total = 0;
  int bad   = 0;
  int pulses = 0;

  always @(negedge clk) if (frame_start) pulses++;

  typedef struct {
    logic [7:0]   base;
    logic [7:0]   step;
    int unsigned  busy;
    logic [191:0] exp_data;
    logic [15:0]  exp_count;
  } vec_t;

  vec_t vecs[4];

  task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic last);
    int unsigned n;
    n = 0;
    s_valid = 1'b1;
    s_data  = b;
    s_last  = last;
    while (!s_ready && n < 200) begin
      tick();
      n++;
    end
    if (!s_ready) begin
      total++;
      bad++;
      $display("FAIL send_timeout: s_ready got 0 want 1 for byte %0h", b);
    end
    tick();
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] base, input logic [7:0] step);
    for (int i = 0; i < 24; i++) send_byte(base + step * 8'(i), 1'b0);
  endtask

  task automatic done_pulse();
    ds_done = 1'b1;
    tick();
    ds_done = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    logic [15:0] exp_cnt;

    vecs[0] = '{8'h01, 8'h01, 0,  192'h0102030405060708090a0b0c0d0e0f101112131415161718, 16'd1};
    vecs[1] = '{8'hf0, 8'h01, 10, 192'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff0001020304050607, 16'd2};
    vecs[2] = '{8'h80, 8'h02, 3,  192'h80828486888a8c8e90929496989a9c9ea0a2a4a6a8aaacae, 16'd3};
    vecs[3] = '{8'haa, 8'h00, 0,  {24{8'haa}}, 16'd4};

    reset = 1'b1; s_data = '0; s_valid = 1'b0; s_last = 1'b0; ds_busy = 1'b0; ds_done = 1'b0;
    tick();
    chk("rst_s_ready", s_ready, 0);
    chk("rst_start", frame_start, 0);
    chk("rst_data", frame_data, 0);
    chk("rst_count", frame_count, 0);
    chk("rst_in_flight", in_flight, 0);
    tick(); tick();
    reset = 1'b0;
    tick();
    chk("post_rst_s_ready", s_ready, 1);

    for (int v = 0; v < 4; v++) begin
      ds_busy = (vecs[v].busy != 0);
      send_frame(vecs[v].base, vecs[v].step);
      chk("start_n1", frame_start, 0);
      tick();
      chk("start_n2", frame_start, 0);
      chk("issue_in_flight", in_flight, 1);
      for (int unsigned i = 0; i < vecs[v].busy; i++) begin
        tick();
        chk("busy_no_start", frame_start, 0);
        chk("busy_data_stable", frame_data, vecs[v].exp_data);
      end
      ds_busy = 1'b0;
      tick();
      chk("start_pulse", frame_start, 1);
      chk("frame_data", frame_data, vecs[v].exp_data);
      chk("frame_count", frame_count, vecs[v].exp_count);
      chk("count_small", count_s, vecs[v].exp_count[2:0]);
      tick();
      chk("pulse_len", frame_start, 0);
      done_pulse();
      chk("idle_in_flight", in_flight, 0);
    end

    // Two frames with no completion: second must wait fully assembled behind the first.
    p0 = pulses;
    send_frame(8'haa, 8'h00);
    send_frame(8'h55, 8'h00);
    chk("bp_s_ready_low", s_ready, 0);
    tick(); tick(); tick();
    chk("bp_s_ready_held", s_ready, 0);
    chk("bp_data_held", frame_data, {24{8'haa}});
    chk("bp_pulses", pulses - p0, 1);
    done_pulse();
    chk("bp_s_ready_back", s_ready, 1);
    chk("bp_data_loaded", frame_data, {24{8'h55}});
    chk("bp_start_d1", frame_start, 0);
    tick();
    chk("bp_start_d2", frame_start, 1);
    chk("bp_count", frame_count, 6);
    tick();
    done_pulse();
    chk("bp_pulses_total", pulses - p0, 2);

    // Counter wrap on the 3-bit instance: 7 -> 0 -> 1.
    for (int k = 0; k < 3; k++) begin
      exp_cnt = 16'(7 + k);
      send_frame(8'h10, 8'h03);
      tick(); tick(); tick();
      chk("wrap_count", frame_count, exp_cnt);
      chk("wrap_count_small", count_s, exp_cnt[2:0]);
      done_pulse();
    end

    // Reset part way through a frame discards the partial bytes.
    send_frame_partial: for (int i = 0; i < 10; i++) send_byte(8'h20 + 8'(i), 1'b0);
    reset = 1'b1;
    tick();
    chk("mid_rst_s_ready", s_ready, 0);
    chk("mid_rst_count", frame_count, 0);
    chk("mid_rst_data", frame_data, 0);
    chk("mid_rst_in_flight", in_flight, 0);
    tick();
    reset = 1'b0;
    tick();
    chk("mid_rst_ready_back", s_ready, 1);
    p0 = pulses;
    send_frame(8'hc3, 8'h00);
    repeat (6) tick();
    chk("mid_rst_pulses", pulses - p0, 1);
    chk("mid_rst_frame", frame_data, {24{8'hc3}});
    chk("mid_rst_count_after", frame_count, 1);
    chk("mid_rst_count_small", count_s, 1);
    done_pulse();

    // Short message terminated by s_last.
    p0 = pulses;
    send_byte(8'hde, 1'b0);
    send_byte(8'had, 1'b0);
    send_byte(8'hbe, 1'b1);
    repeat (6) tick();
`ifdef FRAME_PACKER_ZERO_PAD_EN
    chk("pad_pulses", pulses - p0, 1);
    chk("pad_frame", frame_data, {24'hdeadbe, 168'h0});
    chk("pad_count", frame_count, 2);
    done_pulse();
`else
    chk("nopad_pulses", pulses - p0, 0);
    chk("nopad_in_flight", in_flight, 0);
    chk("nopad_s_ready", s_ready, 1);
    chk("nopad_count", frame_count, 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
